// File: rtl/approx_add_sched.sv
// rtl/approx_add_sched.sv - round-robin scheduler sharing one exact/approximate 16-bit adder
module approx_add_sched #(
    parameter int NUM_REQ    = 4,
    parameter int APPROX_LSB = 12,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_approx,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [16:0]          rsp_sum,
    output logic                 rsp_approx,
    output logic [CNT_W-1:0]     cnt_exact,
    output logic [CNT_W-1:0]     cnt_approx
);

    localparam int K = APPROX_LSB;

    // Requester vectors padded to the 8-requester maximum so a 3-bit index
    // always selects exactly within range.
    logic [7:0]   valid_pad;
    logic [7:0]   approx_pad;
    logic [127:0] a_pad;
    logic [127:0] b_pad;

    logic [2:0]   ptr;
    logic         can_accept;
    logic         grant_any;
    logic [2:0]   grant_idx;
    logic [7:0]   ready_pad;
    logic [15:0]  sel_a;
    logic [15:0]  sel_b;
    logic         sel_approx;
    logic [16:0]  exact_sum;
    logic [16:0]  approx_hi;
    logic [16:0]  approx_sum;
    logic [2:0]   ptr_next;

    assign valid_pad  = 8'(req_valid);
    assign approx_pad = 8'(req_approx);
    assign a_pad      = 128'(req_a);
    assign b_pad      = 128'(req_b);

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        int       idx_int;
        logic [2:0] idx;
        can_accept = !rsp_valid || rsp_ready;
        grant_any  = 1'b0;
        grant_idx  = 3'd0;
        idx_int    = 0;
        idx        = 3'd0;
        // Scan from the farthest offset down so the nearest valid one wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx_int = (int'(ptr) + off) % NUM_REQ;
            idx     = idx_int[2:0];
            if (valid_pad[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        if (!rst_n || !can_accept) begin
            grant_any = 1'b0;
        end
    end

    // One-hot ready for the granted requester only.
    always_comb begin
        ready_pad = 8'd0;
        if (grant_any) begin
            ready_pad = 8'd1 << grant_idx;
        end
        req_ready = ready_pad[NUM_REQ-1:0];
    end

    // Operand mux and both adder flavours; the approximate one ignores A's low
    // bits entirely and only uses B[K-1] as a carry-in guess.
    always_comb begin
        sel_a      = a_pad[{grant_idx, 4'b0000} +: 16];
        sel_b      = b_pad[{grant_idx, 4'b0000} +: 16];
        sel_approx = approx_pad[grant_idx];
        exact_sum  = {1'b0, sel_a} + {1'b0, sel_b};
        approx_hi  = 17'(sel_a >> K) + 17'(sel_b >> K) + 17'(sel_b[K-1]);
        approx_sum = approx_hi << K;
    end

    // Pointer moves just past the granted requester.
    always_comb begin
        if (grant_idx == 3'(NUM_REQ - 1)) begin
            ptr_next = 3'd0;
        end else begin
            ptr_next = grant_idx + 3'd1;
        end
    end

    // Result register, round-robin pointer and saturating mode counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 3'd0;
            rsp_sum    <= 17'd0;
            rsp_approx <= 1'b0;
            ptr        <= 3'd0;
            cnt_exact  <= '0;
            cnt_approx <= '0;
        end else begin
            if (grant_any) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= grant_idx;
                rsp_sum    <= sel_approx ? approx_sum : exact_sum;
                rsp_approx <= sel_approx;
                ptr        <= ptr_next;
                if (sel_approx) begin
                    if (cnt_approx != '1) begin
                        cnt_approx <= cnt_approx + CNT_W'(1);
                    end
                end else begin
                    if (cnt_exact != '1) begin
                        cnt_exact <= cnt_exact + CNT_W'(1);
                    end
                end
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_approx_add_sched.sv
// tb/tb_approx_add_sched.sv - scoreboard bench for approx_add_sched
module tb_approx_add_sched;

    localparam int N  = 4;
    localparam int K  = 12;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [16*N-1:0]   req_a;
    logic [16*N-1:0]   req_b;
    logic [N-1:0]      req_approx;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic [16:0]       rsp_sum;
    logic              rsp_approx;
    logic [CW-1:0]     cnt_exact;
    logic [CW-1:0]     cnt_approx;

    approx_add_sched #(.NUM_REQ(N), .APPROX_LSB(K), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_approx (req_approx),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_approx (rsp_approx),
        .cnt_exact  (cnt_exact),
        .cnt_approx (cnt_approx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int sum;
        bit approx;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int   m_ptr, m_valid, m_cexact, m_capprox;

    // Stimulus shadow, applied at the falling edge
    logic [N-1:0] v_valid, v_approx;
    logic         v_rready;
    int           a_op[N];
    int           b_op[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_sum(input int a, input int b, input bit ap);
        if (!ap) return a + b;
        return ((a >> K) + (b >> K) + ((b >> (K - 1)) & 1)) << K;
    endfunction

    task automatic apply_inputs();
        req_valid  = v_valid;
        req_approx = v_approx;
        rsp_ready  = v_rready;
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = 16'(a_op[i]);
            req_b[16*i +: 16] = 16'(b_op[i]);
        end
    endtask

    task automatic step();
        int g;
        int exp_ready;
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        apply_inputs();
        #4;
        g = -1;
        if (m_valid == 0 || v_rready) begin
            for (int off = 0; off < N; off++) begin
                int idx;
                idx = (m_ptr + off) % N;
                if (v_valid[idx]) begin
                    g = idx;
                    break;
                end
            end
        end
        exp_ready = (g >= 0) ? (1 << g) : 0;
        check("req_ready", 32'(req_ready), exp_ready);
        check("rsp_valid", 32'(rsp_valid), m_valid);
        check("cnt_exact", 32'(cnt_exact), m_cexact);
        check("cnt_approx", 32'(cnt_approx), m_capprox);
        if (g >= 0) begin
            e.id     = g;
            e.approx = v_approx[g];
            e.sum    = ref_sum(a_op[g], b_op[g], v_approx[g]);
            sb.push_back(e);
            m_valid = 1;
            m_ptr   = (g + 1) % N;
            if (e.approx) m_capprox = (m_capprox < CMAX) ? m_capprox + 1 : CMAX;
            else          m_cexact  = (m_cexact  < CMAX) ? m_cexact  + 1 : CMAX;
        end else if (m_valid != 0 && v_rready) begin
            m_valid = 0;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v_valid = 4'(N'($urandom)) | 4'b0001;
        apply_inputs();
        #4;
        check("req_ready_in_reset", 32'(req_ready), 0);
        @(posedge clk);
        m_ptr = 0; m_valid = 0; m_cexact = 0; m_capprox = 0;
        sb.delete();
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_sum", 32'(rsp_sum), 0);
        check("rst_rsp_approx", 32'(rsp_approx), 0);
        check("rst_cnt_exact", 32'(cnt_exact), 0);
        check("rst_cnt_approx", 32'(cnt_approx), 0);
    endtask

    task automatic set_idle();
        v_valid  = '0;
        v_approx = '0;
        v_rready = 1'b1;
    endtask

    // Monitor: compares the registered result with the oldest expectation,
    // retiring it only on an accepted handshake.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got id %0d sum %0h with no expected result", rsp_id, rsp_sum);
                end else begin
                    check("rsp_id", 32'(rsp_id), sb[0].id);
                    check("rsp_sum", 32'(rsp_sum), sb[0].sum);
                    check("rsp_approx", 32'(rsp_approx), 32'(sb[0].approx));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        for (int i = 0; i < N; i++) begin
            a_op[i] = 0;
            b_op[i] = 0;
        end
        do_reset();

        // Exact carry-out case
        set_idle();
        v_valid = 4'b0001; a_op[0] = 16'hFFFF; b_op[0] = 16'h0001;
        step();
        #1 check("first_rsp_sum", 32'(rsp_sum), 32'h10000);
        check("first_cnt_exact", 32'(cnt_exact), 1);
        set_idle(); step();

        // Approximate mode on requester 2
        v_valid = 4'b0100; v_approx = 4'b0100;
        a_op[2] = 16'h1234; b_op[2] = 16'h0FFF;
        step();
        #1 check("approx_sum_1", 32'(rsp_sum), 32'h02000);
        a_op[2] = 16'hF000; b_op[2] = 16'hF000;
        step();
        #1 check("approx_sum_2", 32'(rsp_sum), 32'h1E000);
        check("approx_cnt", 32'(cnt_approx), 2);
        set_idle(); step();

        // Round robin with all requesters valid
        do_reset();
        for (int c = 0; c < 6; c++) begin
            v_valid = 4'b1111; v_approx = 4'(N'($urandom)); v_rready = 1'b1;
            for (int i = 0; i < N; i++) begin
                a_op[i] = int'($urandom_range(0, 65535));
                b_op[i] = int'($urandom_range(0, 65535));
            end
            step();
            #1 check("rr_order", 32'(rsp_id), c % N);
        end

        // Backpressure for three cycles, then drain and grant together
        v_rready = 1'b0;
        for (int c = 0; c < 3; c++) step();
        v_rready = 1'b1;
        step();
        #1 check("bp_rsp_valid_kept", 32'(rsp_valid), 1);
        set_idle(); step();

        // Counter saturation
        do_reset();
        for (int c = 0; c < 17; c++) begin
            v_valid = 4'b0001; v_approx = 4'b0001; v_rready = 1'b1;
            a_op[0] = int'($urandom_range(0, 65535));
            b_op[0] = int'($urandom_range(0, 65535));
            step();
        end
        set_idle(); step();
        #1 check("sat_cnt_approx", 32'(cnt_approx), 15);
        check("sat_cnt_exact", 32'(cnt_exact), 0);

        // Reset while a result is pending and requests are waiting
        v_valid = 4'b1111; v_approx = 4'b0000; v_rready = 1'b0;
        step(); step();
        do_reset();
        set_idle();
        v_valid = 4'b1010;
        step();
        #1 check("post_reset_grant", 32'(rsp_id), 1);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            v_valid  = 4'(N'($urandom));
            v_approx = 4'(N'($urandom));
            v_rready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                a_op[i] = int'($urandom_range(0, 65535));
                b_op[i] = int'($urandom_range(0, 65535));
            end
            step();
        end

        set_idle();
        for (int c = 0; c < 3; c++) step();
        #1 check("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
